// File: rtl/rr_mux_arbiter_pkg.sv
// Shared sizing and state encoding for the round-robin capture arbiter.
package mux_arb_pkg;
  localparam int NREQ  = 32;
  localparam int SEL_W = 5;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;
endpackage

// File: rtl/rr_mux_arbiter_if.sv
// Requester-side and downstream-side signals of the arbiter, bundled.
interface rr_mux_arbiter_if #(parameter int WIDTH = 5);
  import mux_arb_pkg::*;

  logic [NREQ-1:0]            req;
  logic [NREQ-1:0]            req_mask;
  logic [NREQ-1:0][WIDTH-1:0] din;
  logic [NREQ-1:0]            gnt;
  logic                       out_valid;
  logic                       out_ready;
  logic [WIDTH-1:0]           out_data;
  logic [SEL_W-1:0]           out_src;

  modport master (output req, req_mask, din, out_ready,
                  input  gnt, out_valid, out_data, out_src);
  modport slave  (input  req, req_mask, din, out_ready,
                  output gnt, out_valid, out_data, out_src);
endinterface

// File: rtl/rr_mux_arbiter_pick.sv
// Round-robin winner search: rotate so ptr sits at bit 0, take the lowest
// set bit, then add ptr back (mod 32) to get the absolute index.
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [NREQ-1:0]  elig,
  input  logic [SEL_W-1:0] ptr,
  output logic             found,
  output logic [SEL_W-1:0] win
);
  logic [NREQ-1:0]  rot;
  logic [SEL_W-1:0] off;

  assign rot = NREQ'({elig, elig} >> ptr);

  always_comb begin
    off = '0;
    for (int i = NREQ-1; i >= 0; i--)
      if (rot[i]) off = SEL_W'(i);
  end

  assign found = |elig;
  assign win   = off + ptr;
endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin 32:1 capture arbiter feeding a one-entry output register
// with a valid/ready handshake downstream.
module rr_mux_arbiter
  import mux_arb_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input logic              clk,
  input logic              rst_n,
  rr_mux_arbiter_if.slave  bus
);
  state_e           state_q, state_d;
  logic [SEL_W-1:0] ptr_q, src_q, win;
  logic [WIDTH-1:0] data_q, sel_data;
  logic [NREQ-1:0]  elig;
  logic             found, capture;

  assign elig = bus.req & bus.req_mask;

  rr_pick u_pick (
    .elig  (elig),
    .ptr   (ptr_q),
    .found (found),
    .win   (win)
  );

  assign sel_data = bus.din[win];

  // Reset gates capture so no grant leaks out while rst_n is low.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    if (rst_n) begin
      case (state_q)
        EMPTY: if (found) begin
          capture = 1'b1;
          state_d = FULL;
        end
        FULL: if (bus.out_ready) begin
          if (found) capture = 1'b1;
          else       state_d = EMPTY;
        end
      endcase
    end
  end

  always_comb begin
    bus.gnt = '0;
    if (capture) bus.gnt[win] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
      data_q  <= '0;
      src_q   <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        data_q <= sel_data;
        src_q  <= win;
        ptr_q  <= win + 1'b1;
      end
    end
  end

  assign bus.out_valid = (state_q == FULL);
  assign bus.out_data  = data_q;
  assign bus.out_src   = src_q;
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Self-checking bench for rr_mux_arbiter: behavioural round-robin model,
// scoreboard of captured words, vector table plus directed corner sequences.
module tb_rr_mux_arbiter;
  localparam int WIDTH = 5;

  typedef struct {
    logic [31:0] req;
    logic [31:0] mask;
    logic        rdy;
    logic [31:0] gnt;
  } vec_t;

  typedef struct {
    logic [4:0]       src;
    logic [WIDTH-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rr_mux_arbiter_if #(.WIDTH(WIDTH)) bus ();
  rr_mux_arbiter #(.WIDTH(WIDTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int failures = 0;

  logic             m_full;
  int               m_ptr;
  logic [4:0]       m_src;
  logic [WIDTH-1:0] m_data;
  exp_t             sbq[$];
  vec_t             tbl[$];

  function automatic logic [WIDTH-1:0] din_of(int i);
    logic [WIDTH-1:0] v;
    v = WIDTH'(i) ^ WIDTH'(5'h15);
    return v;
  endfunction

  function automatic int pick(logic [31:0] e, int p);
    for (int k = 0; k < 32; k++)
      if (e[(p + k) % 32]) return (p + k) % 32;
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%08h expected=%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_full = 1'b0;
    m_ptr  = 0;
    m_src  = '0;
    m_data = '0;
    sbq.delete();
  endtask

  // One clock cycle, entered and left at posedge+1.
  task automatic cyc(input logic [31:0] r, input logic [31:0] m, input logic rdy,
                     output logic [31:0] g);
    logic [31:0] eg;
    logic        cap;
    int          w;
    exp_t        e;
    bus.req       = r;
    bus.req_mask  = m;
    bus.out_ready = rdy;
    #3;
    w   = pick(r & m, m_ptr);
    cap = (w >= 0) && (!m_full || rdy);
    eg  = cap ? (32'h1 << w) : 32'h0;
    g   = bus.gnt;
    chk("gnt", g, eg);
    if (cap) begin
      e.src  = 5'(w);
      e.data = din_of(w);
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    if (cap) begin
      m_full = 1'b1;
      m_ptr  = (w + 1) % 32;
      if (sbq.size() == 0) begin
        checks++; failures++;
        $display("FAIL scoreboard_empty at %0t", $time);
      end else begin
        e = sbq.pop_front();
        m_src  = e.src;
        m_data = e.data;
        chk("cap_src", 32'(bus.out_src), 32'(e.src));
        chk("cap_data", 32'(bus.out_data), 32'(e.data));
      end
    end else begin
      if (m_full && rdy) m_full = 1'b0;
      if (m_full) begin
        chk("hold_src", 32'(bus.out_src), 32'(m_src));
        chk("hold_data", 32'(bus.out_data), 32'(m_data));
      end
    end
    chk("out_valid", 32'(bus.out_valid), 32'(m_full));
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.req       = '1;
    bus.req_mask  = '1;
    bus.out_ready = 1'b1;
    model_reset();
    @(posedge clk); #1;
    chk("rst_gnt", bus.gnt, 32'h0);
    chk("rst_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_data", 32'(bus.out_data), 32'h0);
    chk("rst_src", 32'(bus.out_src), 32'h0);
    @(posedge clk); #1;
    bus.req = '0;
    rst_n   = 1'b1;
  endtask

  function automatic vec_t mk(logic [31:0] r, logic [31:0] m, logic rdy, logic [31:0] g);
    vec_t v;
    v.req = r; v.mask = m; v.rdy = rdy; v.gnt = g;
    return v;
  endfunction

  initial begin
    logic [31:0] g;

    // Full sweep 0..31,0 then drain, masked pair, wrap at 31, lone requester.
    for (int i = 0; i < 33; i++) tbl.push_back(mk('1, '1, 1'b1, 32'h1 << (i % 32)));
    tbl.push_back(mk(32'h0, '1, 1'b1, 32'h0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(32'h0000_0F00, 32'h0000_0A00, 1'b1, (i % 2 == 0) ? 32'h200 : 32'h800));
    tbl.push_back(mk(32'h4000_0000, '1, 1'b1, 32'h4000_0000));
    tbl.push_back(mk(32'h8000_0001, '1, 1'b1, 32'h8000_0000));
    tbl.push_back(mk(32'h8000_0001, '1, 1'b1, 32'h0000_0001));
    tbl.push_back(mk(32'h8000_0001, '1, 1'b1, 32'h8000_0000));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(32'h10, '1, 1'b1, 32'h10));
    tbl.push_back(mk(32'h0, '1, 1'b1, 32'h0));

    for (int i = 0; i < 32; i++) bus.din[i] = din_of(i);
    bus.req = '0; bus.req_mask = '1; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    do_reset();

    // Single requester 0: same-cycle grant, registered word next cycle.
    cyc(32'h1, '1, 1'b1, g);
    chk("first_gnt", g, 32'h1);
    chk("first_data", 32'(bus.out_data), 32'h15);
    chk("first_src", 32'(bus.out_src), 32'h0);
    cyc(32'h0, '1, 1'b1, g);

    do_reset();
    foreach (tbl[i]) begin
      cyc(tbl[i].req, tbl[i].mask, tbl[i].rdy, g);
      chk($sformatf("tbl_gnt[%0d]", i), g, tbl[i].gnt);
    end

    // Back-pressure: word from 3 held while 7 waits, then 7 goes through.
    cyc(32'h8, '1, 1'b1, g);
    for (int i = 0; i < 4; i++) begin
      cyc(32'h80, '1, 1'b0, g);
      chk("bp_gnt", g, 32'h0);
      chk("bp_src", 32'(bus.out_src), 32'h3);
    end
    cyc(32'h80, '1, 1'b1, g);
    chk("bp_release_gnt", g, 32'h80);
    chk("bp_release_src", 32'(bus.out_src), 32'h7);

    // Mask dropping everyone in the same cycle empties without a grant.
    cyc('1, 32'h0, 1'b1, g);
    chk("mask_gnt", g, 32'h0);
    chk("mask_keep_src", 32'(bus.out_src), 32'h7);

    for (int i = 0; i < 60; i++)
      cyc($urandom & $urandom, $urandom | $urandom, 1'($urandom_range(0, 1)), g);

    // Reset mid-hold: word drops at once, and search restarts from 0.
    cyc(32'h20, '1, 1'b1, g);
    cyc(32'h200, '1, 1'b0, g);
    bus.req = '1;
    rst_n   = 1'b0;
    #1;
    chk("midrst_valid", 32'(bus.out_valid), 32'h0);
    chk("midrst_gnt", bus.gnt, 32'h0);
    model_reset();
    @(posedge clk); #1;
    chk("midrst_gnt2", bus.gnt, 32'h0);
    rst_n = 1'b1;
    cyc(32'h0010_0004, '1, 1'b1, g);
    chk("post_rst_gnt", g, 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rr_mux_arbiter.md
RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

Interface
REQ-001 Parameter WIDTH, default 5, bit width of each requester data word.
REQ-002 Parameter NREQ, fixed at 32, number of requesters; select index is 5 bits.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 req  input  32  per-requester request; req[i] high = din[i] valid.
REQ-007 din  input  32 x WIDTH  per-requester data, packed array indexed by requester.
REQ-008 req_mask  input  32  requester enable; masked-off requesters are never granted.
REQ-009 gnt  output  32  one-hot grant pulse, one cycle, marks capture of din[i].
REQ-010 out_valid  output  1  out_data/out_src hold a captured word.
REQ-011 out_ready  input  1  downstream accepts the word when out_valid && out_ready.
REQ-012 out_data  output  WIDTH  captured data word.
REQ-013 out_src  output  5  index of the requester that supplied out_data.

Function
REQ-014 Eligible set SHALL be req & req_mask.
REQ-015 Two states SHALL exist: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-016 Capture SHALL occur in a cycle when the eligible set is nonzero and (state EMPTY, or state FULL with out_ready=1).
REQ-017 On capture, the winner SHALL be the first eligible index searching upward from ptr, wrapping 31->0.
REQ-018 On capture, gnt[winner]=1 combinationally in that cycle; out_data<=din[winner], out_src<=winner, state<=FULL, ptr<=winner+1 mod 32.
REQ-019 gnt SHALL be all-zero in any cycle without capture; at most one bit is ever set.
REQ-020 FULL with out_ready=1 and no eligible requester SHALL go to EMPTY; out_data/out_src keep their last values.
REQ-021 FULL with out_ready=0 SHALL hold out_valid, out_data, out_src and ptr unchanged; gnt=0.
REQ-022 Latency: req in cycle n with state EMPTY -> out_valid=1 in cycle n+1.
REQ-023 Throughput: with out_ready held high and continuous requests, one capture per cycle, no bubble.
REQ-024 Requester i SHALL hold req[i] and din[i] stable until it sees gnt[i]; the block does not buffer unrequested data.
REQ-025 req_mask changes SHALL take effect in the same cycle; an already captured word is unaffected.
REQ-026 A lone persistent requester SHALL be granted every capture cycle (ptr wraps past it and back).

Reset
REQ-027 While rst_n=0: state EMPTY, out_valid=0, out_data=0, out_src=0, ptr=0, gnt=0.
REQ-028 Reset asserted mid-operation SHALL drop a held word immediately; no grant is issued in a reset cycle.
REQ-029 First capture after reset release SHALL search from index 0.

Structure
REQ-030 Package mux_arb_pkg SHALL hold NREQ, SEL_W=5 and the state enum (EMPTY, FULL).
REQ-031 Sub-module rr_pick SHALL compute the winner index and found flag from eligible vector and ptr (rotate, priority-encode, un-rotate), purely combinational.
REQ-032 Data selection SHALL be a 32:1 WIDTH-bit mux indexed by the winner.

Verification
REQ-033 Reset, then req=32'h1, din[0]=5'h15, out_ready=1 -> gnt=32'h1 that cycle; next cycle out_valid=1, out_data=5'h15, out_src=0.
REQ-034 req=32'hFFFFFFFF, mask all ones, out_ready=1 for 33 cycles -> out_src sequence 0,1,...,31,0; one gnt bit per cycle.
REQ-035 FULL with out_src=3, out_ready=0 for 4 cycles while req[7]=1 -> outputs unchanged, gnt=0; on out_ready=1 gnt[7]=1, next out_src=7.
REQ-036 req=32'h80000001, ptr=31 -> grant 31 then 0 (wrap-around).
REQ-037 req=32'h00000F00, req_mask=32'h00000A00 -> only requesters 9 and 11 granted, alternating.
REQ-038 rst_n driven low while FULL with out_ready=0 -> out_valid=0 immediately, gnt=0; after release first grant searches from 0.
